// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: widths, schedule FSM states, rotate helper and round constants.
// Used by the message-schedule generator and the round function.
// Pure declarations; no logic or state.
package sha1_pkg;

  localparam int SHA1_WORD_W  = 32;
  localparam int SHA1_BLOCK_W = 512;
  localparam int SHA1_ROUNDS  = 80;

  // Schedule generator control state
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sha1_sched_state_e;

  // Round constants, one per group of 20 rounds
  localparam logic [SHA1_WORD_W-1:0] SHA1_K0 = 32'h5A827999;
  localparam logic [SHA1_WORD_W-1:0] SHA1_K1 = 32'h6ED9EBA1;
  localparam logic [SHA1_WORD_W-1:0] SHA1_K2 = 32'h8F1BBCDC;
  localparam logic [SHA1_WORD_W-1:0] SHA1_K3 = 32'hCA62C1D6;

  // One-bit left rotate of a 32-bit word
  function automatic logic [SHA1_WORD_W-1:0] rotl1(input logic [SHA1_WORD_W-1:0] x);
    return {x[SHA1_WORD_W-2:0], x[SHA1_WORD_W-1]};
  endfunction

endpackage

// File: rtl/sha1_w_expand.sv
// SHA-1 schedule expansion step: W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]).
// Latency: purely combinational, zero cycles.
// No handshake; kept standalone so an unrolled schedule can instantiate several copies.
module sha1_w_expand
  import sha1_pkg::*;
(
  input  logic [SHA1_WORD_W-1:0] i_w_t0,
  input  logic [SHA1_WORD_W-1:0] i_w_t2,
  input  logic [SHA1_WORD_W-1:0] i_w_t8,
  input  logic [SHA1_WORD_W-1:0] i_w_t13,
  output logic [SHA1_WORD_W-1:0] o_w_t16
);

  logic [SHA1_WORD_W-1:0] w_mix;

  // XOR of the four taps, then the single-bit rotate
  always_comb begin
    w_mix   = i_w_t13 ^ i_w_t8 ^ i_w_t2 ^ i_w_t0;
    o_w_t16 = rotl1(w_mix);
  end

endmodule

// File: rtl/sha1_w_schedule.sv
// SHA-1 message schedule: takes one 512-bit block, emits W[0..NUM_ROUNDS-1] with round index.
// Latency: W0 valid the cycle after block accept, one word per cycle while w_ready is high.
// Backpressure: w_ready low freezes all state; blocks accepted only in IDLE (or on the final
// transfer when SHA1_WSCHED_B2B_EN is defined, giving bubble-free back-to-back blocks).
// NUM_ROUNDS must lie in 17..80; smaller values are for reduced-round experiments only.
module sha1_w_schedule
  import sha1_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA1_ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [SHA1_BLOCK_W-1:0] blk_data,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [SHA1_WORD_W-1:0]  w,
  output logic [6:0]              round,
  output logic                    last
);

  localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

  sha1_sched_state_e      r_state;
  logic [SHA1_WORD_W-1:0] r_buf [16];
  logic [6:0]             r_round;

  logic                   w_is_run;
  logic                   w_is_last;
  logic                   w_xfer;
  logic                   w_accept;
  logic [SHA1_WORD_W-1:0] w_next_word;

  // Status decodes come straight from registered state
  assign w_is_run  = (r_state == RUN);
  assign w_is_last = w_is_run && (r_round == LAST_ROUND);
  assign w_xfer    = w_is_run && w_ready;

`ifdef SHA1_WSCHED_B2B_EN
  // The final transfer frees the buffer in the same cycle, so a new block may load then
  assign blk_ready = !w_is_run || (w_is_last && w_ready);
`else
  assign blk_ready = !w_is_run;
`endif

  assign w_accept = blk_valid && blk_ready;

  // Next schedule word computed from the current window W[t..t+15]
  sha1_w_expand u_expand (
    .i_w_t0  (r_buf[0]),
    .i_w_t2  (r_buf[2]),
    .i_w_t8  (r_buf[8]),
    .i_w_t13 (r_buf[13]),
    .o_w_t16 (w_next_word)
  );

  // State, round counter and shift buffer; a block load takes priority over the shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_round <= '0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_state <= RUN;
      r_round <= '0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= blk_data[SHA1_BLOCK_W-1-SHA1_WORD_W*i -: SHA1_WORD_W];
      end
    end else if (w_xfer) begin
      for (int i = 0; i < 15; i++) begin
        r_buf[i] <= r_buf[i+1];
      end
      r_buf[15] <= w_next_word;
      if (w_is_last) begin
        r_state <= IDLE;
        r_round <= '0;
      end else begin
        r_round <= r_round + 7'd1;
      end
    end
  end

  assign w_valid = w_is_run;
  assign w       = r_buf[0];
  assign round   = r_round;
  assign last    = w_is_last;

endmodule

// File: tb/tb_sha1_w_schedule.sv
// Self-checking bench for sha1_w_schedule: random and FIPS "abc" blocks, stalls, busy
// rejection, back-to-back blocks, mid-block reset and a reduced-round instance.
// Expected words come from an array model of the schedule recurrence.
module tb_sha1_w_schedule;
  import sha1_pkg::*;

`ifdef SHA1_WSCHED_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         blk_valid, blk_ready;
  logic [511:0] blk_data;
  logic         w_valid, w_ready, last;
  logic [31:0]  w;
  logic [6:0]   round;

  logic         blk_valid_20, blk_ready_20;
  logic [511:0] blk_data_20;
  logic         w_valid_20, w_ready_20, last_20;
  logic [31:0]  w_20;
  logic [6:0]   round_20;

  logic [31:0]  exp_w [80];
  logic [31:0]  got_w [80];
  int           n_vec;
  int           n_err;

  sha1_w_schedule dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .w_valid(w_valid), .w_ready(w_ready), .w(w), .round(round), .last(last)
  );

  sha1_w_schedule #(.NUM_ROUNDS(20)) dut20 (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid_20), .blk_ready(blk_ready_20), .blk_data(blk_data_20),
    .w_valid(w_valid_20), .w_ready(w_ready_20), .w(w_20), .round(round_20), .last(last_20)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Schedule straight from the definition: words 0..15 from the block, rest by recurrence
  task automatic load_model(input logic [511:0] m);
    for (int i = 0; i < 16; i++) exp_w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 80; i++)
      exp_w[i] = rol(exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16], 1);
  endtask

  // SHA-1 compression of the captured words from the standard initial hash
  task automatic digest(output logic [159:0] d);
    logic [31:0] h [5];
    logic [31:0] a, b, c, dd, e, f, k, tmp;
    h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
    h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
    a = h[0]; b = h[1]; c = h[2]; dd = h[3]; e = h[4];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & dd);           k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ dd;                    k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & dd) | (c & dd); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ dd;                    k = 32'hCA62C1D6; end
      tmp = rol(a, 5) + f + e + k + got_w[t];
      e = dd; dd = c; c = rol(b, 30); b = a; a = tmp;
    end
    d = {h[0] + a, h[1] + b, h[2] + c, h[3] + dd, h[4] + e};
  endtask

  // Present a block while idle; it is accepted on the next edge
  task automatic offer(input logic [511:0] m);
    blk_data  = m;
    blk_valid = 1'b1;
    w_ready   = 1'b1;
    #1;
    check_val("blk_ready_idle", 64'(blk_ready), 64'd1);
    check_val("w_valid_idle", 64'(w_valid), 64'd0);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    blk_data  = rand_blk();
  endtask

  // Consume words t = 0..stop_at-1 of the modelled block, checking every cycle
  task automatic stream(input int stop_at, input int stall_at, input bit busy,
                        input bit rand_rdy, input bit hold_blk);
    int t = 0;
    int cyc = 0;
    int stalls = 3;
    bit rdy;
    while (t < stop_at && cyc < 2000) begin
      cyc++;
      rdy = 1'b1;
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      if (t == stall_at && stalls > 0) begin
        rdy = 1'b0;
        stalls--;
      end
      w_ready = rdy;
      if (!hold_blk) begin
        if (busy && t >= 10 && t <= 12) begin
          blk_valid = 1'b1;
          blk_data  = rand_blk();
        end else begin
          blk_valid = 1'b0;
        end
      end
      #1;
      check_val("w_valid", 64'(w_valid), 64'd1);
      check_val("w", 64'(w), 64'(exp_w[t]));
      check_val("round", 64'(round), 64'(t));
      check_val("last", 64'(last), 64'(t == 79));
      check_val("blk_ready_run", 64'(blk_ready), 64'(B2B && t == 79 && rdy));
      if (rdy) begin
        got_w[t] = w;
        t++;
      end
      @(posedge clk); #1;
    end
    if (t < stop_at) check_val("stream_timeout", 64'(t), 64'(stop_at));
  endtask

  task automatic check_idle(input string tag);
    #1;
    check_val({tag, "_w_valid"}, 64'(w_valid), 64'd0);
    check_val({tag, "_blk_ready"}, 64'(blk_ready), 64'd1);
  endtask

  initial begin
    logic [511:0] m_abc, ma, mb;
    logic [159:0] dg;
    int n_xfer;

    n_vec = 0; n_err = 0;
    rst = 1'b1;
    blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
    blk_valid_20 = 1'b0; blk_data_20 = '0; w_ready_20 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_w_valid", 64'(w_valid), 64'd0);
    check_val("rst_round", 64'(round), 64'd0);
    check_val("rst_w", 64'(w), 64'd0);
    check_val("rst_last", 64'(last), 64'd0);
    check_val("rst_blk_ready", 64'(blk_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("post_rst");

    // "abc" block with a 3-cycle stall at round 5 and a foreign block offered at round 10
    m_abc = '0;
    m_abc[511:480] = 32'h61626380;
    m_abc[31:0]    = 32'h00000018;
    load_model(m_abc);
    offer(m_abc);
    stream(80, 5, 1'b1, 1'b0, 1'b0);
    check_idle("abc_end");
    check_val("abc_W0", 64'(got_w[0]), 64'h61626380);
    check_val("abc_W15", 64'(got_w[15]), 64'h00000018);
    check_val("abc_W16", 64'(got_w[16]), 64'hC2C4C700);
    check_val("abc_W17", 64'(got_w[17]), 64'h00000000);
    check_val("abc_W18", 64'(got_w[18]), 64'h00000030);
    digest(dg);
    check_val("dig_h0", 64'(dg[159:128]), 64'hA9993E36);
    check_val("dig_h1", 64'(dg[127:96]),  64'h4706816A);
    check_val("dig_h2", 64'(dg[95:64]),   64'hBA3E2571);
    check_val("dig_h3", 64'(dg[63:32]),   64'h7850C26C);
    check_val("dig_h4", 64'(dg[31:0]),    64'h9CD0D89D);

    // Random blocks under random backpressure
    for (int k = 0; k < 4; k++) begin
      ma = rand_blk();
      load_model(ma);
      offer(ma);
      stream(80, -1, 1'b1, 1'b1, 1'b0);
      check_idle("rand_end");
    end

    // Back-to-back: second block held valid for the whole of the first
    ma = rand_blk();
    mb = rand_blk();
    load_model(ma);
    offer(ma);
    blk_valid = 1'b1;
    blk_data  = mb;
    stream(80, -1, 1'b0, 1'b0, 1'b1);
    load_model(mb);
    if (!B2B) begin
      #1;
      check_val("b2b_gap_w_valid", 64'(w_valid), 64'd0);
      check_val("b2b_gap_blk_ready", 64'(blk_ready), 64'd1);
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
    blk_data  = rand_blk();
    #1;
    check_val("b2b_w0_valid", 64'(w_valid), 64'd1);
    check_val("b2b_w0_round", 64'(round), 64'd0);
    stream(80, -1, 1'b0, 1'b1, 1'b0);
    check_idle("b2b_end");

    // Reset in the middle of a block, then a clean restart
    ma = rand_blk();
    load_model(ma);
    offer(ma);
    stream(40, -1, 1'b0, 1'b0, 1'b0);
    w_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("midrst_w_valid", 64'(w_valid), 64'd0);
    check_val("midrst_round", 64'(round), 64'd0);
    check_val("midrst_blk_ready", 64'(blk_ready), 64'd1);
    check_val("midrst_last", 64'(last), 64'd0);
    check_val("midrst_w", 64'(w), 64'd0);
    @(posedge clk); #1;
    check_idle("midrst_idle");
    mb = rand_blk();
    load_model(mb);
    offer(mb);
    stream(80, -1, 1'b1, 1'b1, 1'b0);
    check_idle("restart_end");

    // Reduced-round instance: exactly 20 transfers, last on round 19
    ma = rand_blk();
    load_model(ma);
    blk_data_20  = ma;
    blk_valid_20 = 1'b1;
    w_ready_20   = 1'b1;
    #1;
    check_val("r20_blk_ready", 64'(blk_ready_20), 64'd1);
    @(posedge clk); #1;
    blk_valid_20 = 1'b0;
    n_xfer = 0;
    for (int c = 0; c < 30; c++) begin
      if (w_valid_20) begin
        if (n_xfer < 80) check_val("r20_w", 64'(w_20), 64'(exp_w[n_xfer]));
        check_val("r20_round", 64'(round_20), 64'(n_xfer));
        check_val("r20_last", 64'(last_20), 64'(n_xfer == 19));
        n_xfer++;
      end
      @(posedge clk); #1;
    end
    check_val("r20_count", 64'(n_xfer), 64'd20);
    check_val("r20_end_w_valid", 64'(w_valid_20), 64'd0);
    check_val("r20_end_blk_ready", 64'(blk_ready_20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha1_w_schedule.md
# sha1_w_schedule

SHA-1 message-schedule generator: the producer side of the per-round `w`/`round` interface consumed by the SHA-1 round function. It accepts one padded 512-bit block and emits one expanded word W[t] per round, together with the round index, for t = 0..NUM_ROUNDS-1. Output transfers use a valid/ready handshake so the round datapath can stall the schedule.

## Interface

Parameters:
- `NUM_ROUNDS`, default 80: rounds emitted per block. Legal range 17..80; values below 80 are for reduced-round experiments only.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `blk_valid`  in  1  input block offered.
- `blk_ready`  out  1  block accepted on `blk_valid && blk_ready`.
- `blk_data`  in  512  message block, M0 in [511:480] through M15 in [31:0] (big-endian word order).
- `w_valid`  out  1  `w`/`round` hold a valid schedule word.
- `w_ready`  in  1  consumer takes the word on `w_valid && w_ready`.
- `w`  out  32  W[t].
- `round`  out  7  t, feeds the round function's `round` input directly.
- `last`  out  1  high while `round == NUM_ROUNDS-1` and `w_valid` is high.

## Operation

- Storage: 16 x 32 shift buffer `buf[0..15]` and a 7-bit round counter.
- States:
  - IDLE: `blk_ready`=1, `w_valid`=0. On block accept, load `buf[i]` = M_i, set `round`=0, go to RUN.
  - RUN: `w_valid`=1, `w`=`buf[0]`, `blk_ready`=0 unless `SHA1_WSCHED_B2B_EN` is defined.
- On each RUN transfer:
  - Shift: `buf[i]` <= `buf[i+1]` for i = 0..14.
  - `buf[15]` <= rotl1(`buf[13]` ^ `buf[8]` ^ `buf[2]` ^ `buf[0]`), i.e. W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]).
  - `round` <= `round` + 1.
- On the transfer with `round == NUM_ROUNDS-1`: go to IDLE, `round` <= 0.
- No transfer (stall, `w_ready`=0): `buf`, `round`, `w` and `last` hold.
- While RUN and not in the B2B accept window:
  - `blk_valid` is ignored.
  - `blk_data` is not sampled.
- All arithmetic is mod 2^32; rotl1 is a 1-bit left rotate. There is no adder in this block.

## Timing

- Reset (sync, dominant over all other inputs): state IDLE, `buf` all zero, `round`=0, `w_valid`=0, `w`=0, `last`=0, `blk_ready`=1 from the first cycle after reset.
- Reset mid-block: the block is abandoned, no further words are emitted, and the block restarts from IDLE.
- Latency: block accepted at cycle N gives W0 valid at N+1. With `w_ready` held high, W[t] is presented at N+1+t.
- Block period with no stalls: 81 cycles without B2B (one IDLE cycle), 80 cycles with B2B.
- `w` and `round` are registered outputs. The `last`, `w_valid` and `blk_ready` decodes come from registered state only; there is no combinational path from `w_ready` to outputs, except the `blk_ready` B2B term.

## Configuration

- `SHA1_WSCHED_B2B_EN` defined:
  - `blk_ready` = IDLE || (`last` && `w_ready`).
  - A block accepted in the same cycle as the final transfer reloads `buf`, sets `round`=0 and stays in RUN, so its W0 appears the next cycle with no bubble.
- `SHA1_WSCHED_B2B_EN` undefined:
  - `blk_ready` = IDLE only.
  - There is always one `w_valid`=0 cycle between blocks.

## Structure

- Shared package `sha1_pkg`:
  - `SHA1_WORD_W`=32, `SHA1_BLOCK_W`=512, `SHA1_ROUNDS`=80.
  - The state enum (IDLE, RUN).
  - The `rotl1` function.
  - The four K constants (shared with the round function).
- Sub-module: `sha1_w_expand`, purely combinational. Four 32-bit words in, W[t+16] out. It is reused by any future unrolled schedule.

## Test plan

- FIPS 180 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), `w_ready`=1 -> outputs:
  - W0=0x61626380, W15=0x00000018.
  - W16=0xC2C4C700, W17=0x00000000, W18=0x00000030.
  - `round` 0..79, `last` high only at round 79.
  - Feeding the round function yields digest A9993E36 4706816A BA3E2571 7850C26C 9CD0D89D.
- Stall: drop `w_ready` for 3 cycles at round 5 -> `w`, `round`=5 and `w_valid`=1 hold; W6 follows on the cycle after `w_ready` returns.
- Busy rejection: assert `blk_valid` with different data at round 10 -> `blk_ready`=0 and the remaining W sequence is unchanged.
- Back-to-back: two blocks offered continuously -> second W0 at cycle N+81 with B2B defined, N+82 without (one `w_valid`=0 gap).
- Reset at round 40 -> next cycle `w_valid`=0, `round`=0, `blk_ready`=1; a new block then restarts cleanly from W0.
- `NUM_ROUNDS`=20 -> exactly 20 transfers, `last` at round 19, return to IDLE.
